pc_unit_ras: RTL and testbench

//  - Parametrised next-generation program counter for the fetch stage.
//  - Generalises the simple PC in three ways: configurable width, word-index or byte addressing, and a

---
 rtl/pc_pkg.sv | 16 +
 rtl/ras_stack.sv | 66 ++++++
 rtl/pc_unit_ras.sv | 126 ++++++++++++
 tb/tb_pc_unit_ras.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package pc_pkg;

  localparam int unsigned ADDR_MODE_WORD = 0;
  localparam int unsigned ADDR_MODE_BYTE = 1;

  // Which source feeds the PC register on the next edge.
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_RAS,
    SRC_BRANCH,
    SRC_INC,
    SRC_HOLD
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Return address stack: circular buffer with a top pointer and an occupancy count.
// A push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            swap,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW:0]     cnt_q, cnt_d;

  // Next-state: push advances the pointer, pop retreats it, swap rewrites the top in place.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d        = ptr_q + PW'(1);
      mem_d[ptr_d] = din;
      if (cnt_q != FULL_CNT) begin
        cnt_d = cnt_q + (PW+1)'(1);
      end
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end else if (swap && (cnt_q != '0)) begin
      mem_d[ptr_q] = din;
    end
  end

  // State registers; reset discards all contents.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with trap redirect, branch targets and a return address stack.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     ADDR_MODE   = 0,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned     RAS_DEPTH   = 4
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  output logic [XLEN-1:0] pc_out,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign,
  output logic            ras_underflow
);

  localparam int unsigned     SHIFT = $clog2(INSTR_BYTES);
  localparam logic [XLEN-1:0] INC   = (ADDR_MODE == ADDR_MODE_WORD) ? XLEN'(1)
                                                                    : XLEN'(INSTR_BYTES);

  // Byte address -> pc_out units.
  function automatic logic [XLEN-1:0] conv(input logic [XLEN-1:0] a);
    if (ADDR_MODE == ADDR_MODE_WORD) begin
      return a >> SHIFT;
    end
    return {a[XLEN-1:SHIFT], SHIFT'(0)};
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            underflow_q, underflow_d;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] ras_top;
  logic            ras_push, ras_pop, ras_swap;
  logic            ras_is_empty, ras_is_full;
  pc_src_e         src;

  assign pc_inc = pc_q + INC;

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .swap  (ras_swap),
    .din   (pc_inc),
    .top   (ras_top),
    .empty (ras_is_empty),
    .full  (ras_is_full)
  );

  // Priority select of the next PC source plus RAS control and flag pulses.
  always_comb begin
    src         = SRC_HOLD;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_swap    = 1'b0;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    if (trap) begin
      src = SRC_TRAP;
    end else if (en) begin
      if (ret && !ras_is_empty) begin
        src = SRC_RAS;
        // ret+call+branch is a co-routine swap: top is replaced, count unchanged.
        if (call && branch_taken) begin
          ras_swap = 1'b1;
        end else begin
          ras_pop = 1'b1;
        end
      end else if (ret && !(call && branch_taken)) begin
        src         = SRC_INC;
        underflow_d = 1'b1;
      end else if (branch_taken) begin
        // Also covers ret+call+branch on an empty stack: plain call.
        src        = SRC_BRANCH;
        ras_push   = call;
        misalign_d = |branch_addr[SHIFT-1:0];
      end else begin
        src = SRC_INC;
      end
    end

    unique case (src)
      SRC_TRAP:   pc_d = conv(TRAP_VEC);
      SRC_RAS:    pc_d = ras_top;
      SRC_BRANCH: pc_d = conv(branch_addr);
      SRC_INC:    pc_d = pc_inc;
      SRC_HOLD:   pc_d = pc_q;
      default:    pc_d = pc_q;
    endcase
  end

  // PC register and one-cycle flag pulses.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc_out        = pc_q;
  assign misalign      = misalign_q;
  assign ras_underflow = underflow_q;
  assign ras_empty     = ras_is_empty;
  assign ras_full      = ras_is_full;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: a word-mode and a byte-mode instance share stimulus, each is checked
// every cycle against a list-based model, with literal expectations pinning the model.
module tb_pc_unit_ras;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, branch_taken = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [31:0] branch_addr = '0;

  logic [31:0] pc0, pc1;
  logic        emp0, full0, mis0, uf0;
  logic        emp1, full1, mis1, uf1;

  int nvec = 0;
  int nerr = 0;

  // Model state: index 0 word mode, index 1 byte mode. Stack is a list, newest last.
  logic [31:0] m_pc  [2];
  logic [31:0] m_stk [2][4];
  int          m_n   [2];
  logic        m_mis [2];
  logic        m_uf  [2];

  always #5 CLK = ~CLK;

  pc_unit_ras #(.XLEN(32), .ADDR_MODE(0), .INSTR_BYTES(4), .RESET_PC(32'h0),
                .TRAP_VEC(32'h100), .RAS_DEPTH(4)) u_dut_word (
    .CLK(CLK), .rst(rst), .en(en), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .call(call), .ret(ret), .trap(trap), .pc_out(pc0), .ras_empty(emp0), .ras_full(full0),
    .misalign(mis0), .ras_underflow(uf0)
  );

  pc_unit_ras #(.XLEN(32), .ADDR_MODE(1), .INSTR_BYTES(4), .RESET_PC(32'h0),
                .TRAP_VEC(32'h100), .RAS_DEPTH(4)) u_dut_byte (
    .CLK(CLK), .rst(rst), .en(en), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .call(call), .ret(ret), .trap(trap), .pc_out(pc1), .ras_empty(emp1), .ras_full(full1),
    .misalign(mis1), .ras_underflow(uf1)
  );

  function automatic logic [31:0] m_conv(input int k, input logic [31:0] a);
    return (k == 0) ? (a >> 2) : (a & 32'hFFFF_FFFC);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_n[k] = 0; m_mis[k] = 1'b0; m_uf[k] = 1'b0;
    end
  endtask

  task automatic m_push(input int k, input logic [31:0] v);
    if (m_n[k] == 4) begin
      for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
      m_stk[k][3] = v;
    end else begin
      m_stk[k][m_n[k]] = v;
      m_n[k]++;
    end
  endtask

  // One clock edge of the specified next-PC rules.
  task automatic model_step();
    logic [31:0] inc, nxt, t;
    if (rst) begin
      m_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      inc = (k == 0) ? 32'd1 : 32'd4;
      nxt = m_pc[k] + inc;
      m_mis[k] = 1'b0;
      m_uf[k]  = 1'b0;
      if (trap) begin
        m_pc[k] = m_conv(k, 32'h100);
      end else if (en) begin
        if (ret && m_n[k] > 0) begin
          t = m_stk[k][m_n[k]-1];
          if (call && branch_taken) m_stk[k][m_n[k]-1] = nxt;
          else m_n[k]--;
          m_pc[k] = t;
        end else if (ret && !(call && branch_taken)) begin
          m_pc[k] = nxt;
          m_uf[k] = 1'b1;
        end else if (branch_taken) begin
          if (call) m_push(k, nxt);
          m_pc[k]  = m_conv(k, branch_addr);
          m_mis[k] = (branch_addr[1:0] != 2'b00);
        end else begin
          m_pc[k] = nxt;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc_word",   pc0,          m_pc[0]);
    chk("emp_word",  32'(emp0),    32'(m_n[0] == 0));
    chk("full_word", 32'(full0),   32'(m_n[0] == 4));
    chk("mis_word",  32'(mis0),    32'(m_mis[0]));
    chk("uf_word",   32'(uf0),     32'(m_uf[0]));
    chk("pc_byte",   pc1,          m_pc[1]);
    chk("emp_byte",  32'(emp1),    32'(m_n[1] == 0));
    chk("full_byte", 32'(full1),   32'(m_n[1] == 4));
    chk("mis_byte",  32'(mis1),    32'(m_mis[1]));
    chk("uf_byte",   32'(uf1),     32'(m_uf[1]));
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic drive(input logic e, input logic bt, input logic [31:0] ba, input logic c,
                       input logic r, input logic tr);
    en = e; branch_taken = bt; branch_addr = ba; call = c; ret = r; trap = tr;
    cyc();
  endtask

  initial begin
    m_reset();
    cyc();
    cyc();
    chk("lit_reset_pc_w", pc0, 32'h0);
    chk("lit_reset_pc_b", pc1, 32'h0);
    chk("lit_reset_emp",  32'({emp0, emp1, full0, full1, mis0, mis1, uf0, uf1}), 32'hC0);
    rst = 1'b0;

    // Sequential advance and a plain branch.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
    chk("lit_inc3_w", pc0, 32'h3);
    chk("lit_inc3_b", pc1, 32'hC);
    drive(1, 1, 32'h40, 0, 0, 0);
    chk("lit_br_w", pc0, 32'h10);
    chk("lit_br_b", pc1, 32'h40);

    // Trap beats branch while stalled, then hold.
    drive(0, 1, 32'h80, 0, 0, 1);
    chk("lit_trap_w", pc0, 32'h40);
    chk("lit_trap_b", pc1, 32'h100);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    chk("lit_hold_b", pc1, 32'h100);

    // Call then return.
    drive(1, 1, 32'h200, 1, 0, 0);
    chk("lit_call_b", pc1, 32'h200);
    chk("lit_call_emp", 32'(emp1), 32'h0);
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_ret_b", pc1, 32'h104);
    chk("lit_ret_emp", 32'(emp1), 32'h1);

    // Five nested calls into a four-entry stack.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h1000 + 32'(i) * 32'h100, 1, 0, 0);
      if (i == 3) chk("lit_full4", 32'(full1), 32'h1);
    end
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_ret1", pc1, 32'h1304);
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_ret2", pc1, 32'h1204);
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_ret3", pc1, 32'h1104);
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_ret4", pc1, 32'h1004);
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_uf_pc", pc1, 32'h1008);
    chk("lit_uf", 32'(uf1), 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_uf_gone", 32'(uf1), 32'h0);

    // Misaligned target is truncated and flagged for one cycle.
    drive(1, 1, 32'h202, 0, 0, 0);
    chk("lit_mis_pc", pc1, 32'h200);
    chk("lit_mis", 32'(mis1), 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_mis_gone", 32'(mis1), 32'h0);

    // Co-routine swap, and ret with branch but no call on an empty stack.
    drive(1, 1, 32'h300, 1, 0, 0);
    drive(1, 1, 32'h500, 1, 1, 0);
    chk("lit_swap_pc", pc1, 32'h204);
    drive(1, 0, 0, 0, 1, 0);
    chk("lit_swap_ret", pc1, 32'h304);
    drive(1, 1, 32'h600, 0, 1, 0);
    drive(1, 1, 32'h700, 1, 1, 0);

    // Wrap at the top of the address space.
    drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("lit_wrap_b", pc1, 32'h0);

    // Asynchronous reset with two entries on the stack.
    drive(1, 1, 32'h40, 1, 0, 0);
    drive(1, 1, 32'h80, 1, 0, 0);
    en = 0; branch_taken = 0; call = 0;
    #2 rst = 1'b1;
    #1;
    chk("lit_arst_pc_w", pc0, 32'h0);
    chk("lit_arst_pc_b", pc1, 32'h0);
    chk("lit_arst_emp", 32'({emp0, emp1}), 32'h3);
    m_reset();
    @(negedge CLK);
    rst = 1'b0;
    drive(1, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
